// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: accepts a start, clears the DDS phase accumulator for one cycle, then steps f_word.
// All outputs registered, one cycle after the deciding edge; no backpressure, start is dropped unless IDLE.
module dds_sweep_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        cfg_loop,
   input  logic [1:0]  cfg_wave_sel,
   input  logic [1:0]  cfg_wave_amp,
   input  logic [7:0]  cfg_phase,
   input  logic [7:0]  cfg_f_start,
   input  logic [7:0]  cfg_f_stop,
   input  logic [7:0]  cfg_f_step,
   input  logic [15:0] cfg_dwell,
   output logic        wave_en,
   output logic [1:0]  wave_sel,
   output logic [1:0]  wave_amp,
   output logic [7:0]  phase_init,
   output logic [7:0]  f_word,
   output logic        busy,
   output logic        step_tick,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic        loop_q;
   logic [7:0]  f_start_q, f_stop_q, f_step_q;
   logic [15:0] dwell_q, dwell_cnt, dwell_cnt_nxt;
   logic [7:0]  f_word_nxt;
   logic        wave_en_nxt, busy_nxt, step_tick_nxt, done_nxt;
   logic        accept;
   logic [8:0]  f_next;
   logic        past_stop;

   // 9-bit sum: an 8-bit carry always lands above any 8-bit stop word
   assign f_next    = {1'b0, f_word} + {1'b0, f_step_q};
   assign past_stop = f_next > {1'b0, f_stop_q};
   assign accept    = (state == IDLE) && start && !abort;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      f_word_nxt    = f_word;
      dwell_cnt_nxt = dwell_cnt;
      wave_en_nxt   = 1'b0;
      busy_nxt      = 1'b0;
      step_tick_nxt = 1'b0;
      done_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt     = SETTLE;
               f_word_nxt    = cfg_f_start;
               dwell_cnt_nxt = cfg_dwell;
               busy_nxt      = 1'b1;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               state_nxt   = RUN;
               wave_en_nxt = 1'b1;
               busy_nxt    = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               wave_en_nxt = 1'b1;
               busy_nxt    = 1'b1;
               if (dwell_cnt != 16'd0) begin
                  dwell_cnt_nxt = dwell_cnt - 16'd1;
               end else if (!past_stop) begin
                  f_word_nxt    = f_next[7:0];
                  step_tick_nxt = 1'b1;
                  dwell_cnt_nxt = dwell_q;
               end else if (loop_q) begin
                  f_word_nxt    = f_start_q;
                  step_tick_nxt = 1'b1;
                  dwell_cnt_nxt = dwell_q;
               end else begin
                  state_nxt   = DONE;
                  wave_en_nxt = 1'b0;
                  busy_nxt    = 1'b0;
                  done_nxt    = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wave_en    <= 1'b0;
         wave_sel   <= 2'd0;
         wave_amp   <= 2'd0;
         phase_init <= 8'd0;
         f_word     <= 8'd0;
         busy       <= 1'b0;
         step_tick  <= 1'b0;
         done       <= 1'b0;
         dwell_cnt  <= 16'd0;
         loop_q     <= 1'b0;
         f_start_q  <= 8'd0;
         f_stop_q   <= 8'd0;
         f_step_q   <= 8'd0;
         dwell_q    <= 16'd0;
      end else begin
         wave_en   <= wave_en_nxt;
         f_word    <= f_word_nxt;
         busy      <= busy_nxt;
         step_tick <= step_tick_nxt;
         done      <= done_nxt;
         dwell_cnt <= dwell_cnt_nxt;
         if (accept) begin
            wave_sel   <= cfg_wave_sel;
            wave_amp   <= cfg_wave_amp;
            phase_init <= cfg_phase;
            loop_q     <= cfg_loop;
            f_start_q  <= cfg_f_start;
            f_stop_q   <= cfg_f_stop;
            f_step_q   <= cfg_f_step;
            dwell_q    <= cfg_dwell;
         end
      end
   end

endmodule
